// File: rtl/k2unred_pkg.sv
// Shared types and elaboration-time helpers for the k2unred post-scaler.
package k2unred_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} k2unred_state_t;

   typedef struct packed {
      int logq;
      int logqh;
      int dbl_per_cyc;
   } k2unred_params_t;

   function automatic int k2unred_logm(input k2unred_params_t p);
      return p.logq - p.logqh;
   endfunction

   // Number of RUN cycles: 2M doublings, DBL_PER_CYC of them per clock.
   function automatic int k2unred_iters(input k2unred_params_t p);
      return (2 * k2unred_logm(p)) / p.dbl_per_cyc;
   endfunction

   function automatic int k2unred_cntw(input k2unred_params_t p);
      return (k2unred_iters(p) <= 1) ? 1 : $clog2(k2unred_iters(p));
   endfunction

endpackage

// File: rtl/k2unred_if.sv
// Valid/ready bus into and out of the k2unred post-scaler.
interface k2unred_if #(
   parameter int LOGQ  = 60,
   parameter int LOGQH = 26
);
   logic             in_valid;
   logic             in_ready;
   logic [LOGQ-1:0]  in_data;
   logic [LOGQH-1:0] qH;
   logic             out_valid;
   logic             out_ready;
   logic [LOGQ-1:0]  out_data;

   modport master (
      output in_valid, in_data, qH, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, qH, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/k2unred_dbl.sv
// One modular doubling: y = 2x mod q, valid for x < q.
module k2unred_dbl #(
   parameter int LOGQ = 60
) (
   input  logic [LOGQ-1:0] x,
   input  logic [LOGQ-1:0] q,
   output logic [LOGQ-1:0] y
);
   logic [LOGQ:0]   dbl;
   logic [LOGQ+1:0] diff;
   logic            unused_hi;

   assign dbl  = {x, 1'b0};
   // Borrow out of the widened subtract means 2x < q, so keep 2x.
   assign diff = {1'b0, dbl} - {2'b00, q};
   assign y    = diff[LOGQ+1] ? dbl[LOGQ-1:0] : diff[LOGQ-1:0];

   assign unused_hi = ^{diff[LOGQ], dbl[LOGQ]};
endmodule

// File: rtl/k2unred.sv
// Iterative post-scaler: out = in * 2^(2M) mod q via 2M chained modular doublings.
module k2unred
   import k2unred_pkg::*;
#(
   parameter int LOGQ        = 60,
   parameter int LOGQH       = 26,
   parameter int DBL_PER_CYC = 4
) (
   input logic   clk,
   input logic   rstn,
   k2unred_if.slave bus
);
   localparam k2unred_params_t P = '{logq: LOGQ, logqh: LOGQH, dbl_per_cyc: DBL_PER_CYC};
   localparam int M     = k2unred_logm(P);
   localparam int ITERS = k2unred_iters(P);
   localparam int CNTW  = k2unred_cntw(P);

   if (((2 * M) % DBL_PER_CYC) != 0) begin : g_bad_cfg
      $error("k2unred: DBL_PER_CYC must divide 2M");
   end

   k2unred_state_t  state, state_nxt;
   logic [LOGQ-1:0] x;
   logic [LOGQ-1:0] q_lat;
   logic [CNTW-1:0] cnt;
   logic            last;

   logic [LOGQ-1:0] q_in;
   logic [LOGQ:0]   ld_diff;
   logic [LOGQ-1:0] x_load;
   logic [LOGQ-1:0] chain [0:DBL_PER_CYC];

   // q = qH * 2^M + 1, taken from the bus only at acceptance.
   assign q_in    = {bus.qH, {(M-1){1'b0}}, 1'b1};
   assign ld_diff = {1'b0, bus.in_data} - {1'b0, q_in};
   assign x_load  = ld_diff[LOGQ] ? bus.in_data : ld_diff[LOGQ-1:0];

   assign chain[0] = x;
   for (genvar i = 0; i < DBL_PER_CYC; i++) begin : g_dbl
      k2unred_dbl #(.LOGQ(LOGQ)) u_dbl (
         .x (chain[i]),
         .q (q_lat),
         .y (chain[i+1])
      );
   end

   assign last          = (cnt == CNTW'(ITERS - 1));
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data  = x;

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.in_valid)  state_nxt = RUN;
         RUN:     if (last)          state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         x     <= '0;
         q_lat <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.in_valid) begin
               q_lat <= q_in;
               x     <= x_load;
               cnt   <= '0;
            end
            RUN: begin
               x   <= chain[DBL_PER_CYC];
               cnt <= cnt + CNTW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_k2unred.sv
// Directed bench: small config (q=193) vector table plus corner sequences, and default-config streaming.
module tb_k2unred;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   k2unred_if #(.LOGQ(8),  .LOGQH(4))  sb ();
   k2unred_if #(.LOGQ(60), .LOGQH(26)) db ();

   k2unred #(.LOGQ(8), .LOGQH(4), .DBL_PER_CYC(2)) dut_s (
      .clk  (clk),
      .rstn (rstn),
      .bus  (sb)
   );

   k2unred #(.LOGQ(60), .LOGQH(26), .DBL_PER_CYC(4)) dut_d (
      .clk  (clk),
      .rstn (rstn),
      .bus  (db)
   );

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Golden model: x * (2^68 mod q) mod q in wide arithmetic.
   function automatic logic [59:0] gold(input logic [59:0] xv, input logic [25:0] qh);
      logic [127:0] q, p, r;
      q = 128'({qh, 33'b0, 1'b1});
      p = (128'd1 << 68) % q;
      r = ({68'b0, xv} * p) % q;
      return r[59:0];
   endfunction

   task automatic send_s(input logic [7:0] din);
      @(negedge clk);
      chk("s_in_ready_idle", 64'(sb.in_ready), 64'd1);
      sb.in_valid = 1'b1;
      sb.in_data  = din;
      sb.qH       = 4'd12;
      @(posedge clk);
      @(negedge clk);
      sb.in_valid = 1'b0;
      sb.in_data  = 8'hA5;
      sb.qH       = 4'd5;
   endtask

   task automatic wait_valid_s(output int lat);
      lat = 0;
      while (!sb.out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input logic [7:0] din, input logic [7:0] exp, input string nm);
      int lat;
      send_s(din);
      wait_valid_s(lat);
      chk({nm, "_latency"}, 64'(lat), 64'd4);
      chk({nm, "_data"}, 64'(sb.out_data), 64'(exp));
      sb.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sb.out_ready = 1'b0;
      chk({nm, "_idle_after"}, 64'({sb.out_valid, sb.in_ready}), 64'b01);
   endtask

   initial begin
      vec_t vt[6];
      int lat;
      logic [59:0]  expq[$];
      logic [25:0]  qh;
      logic [127:0] q128, r128;
      logic [59:0]  xv;
      int acc_n, got_n, last_acc;
      bit done;

      vt = '{'{8'd0, 8'd0}, '{8'd1, 8'd63}, '{8'd2, 8'd126},
             '{8'd3, 8'd189}, '{8'd192, 8'd130}, '{8'd198, 8'd122}};

      sb.in_valid = 1'b0; sb.in_data = '0; sb.qH = '0; sb.out_ready = 1'b0;
      db.in_valid = 1'b0; db.in_data = '0; db.qH = '0; db.out_ready = 1'b0;

      // Reset values
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      chk("rst_s_in_ready",  64'(sb.in_ready),  64'd1);
      chk("rst_s_out_valid", 64'(sb.out_valid), 64'd0);
      chk("rst_s_out_data",  64'(sb.out_data),  64'd0);
      chk("rst_d_in_ready",  64'(db.in_ready),  64'd1);
      chk("rst_d_out_valid", 64'(db.out_valid), 64'd0);
      chk("rst_d_out_data",  64'(db.out_data),  64'd0);

      for (int i = 0; i < 6; i++)
         run_vec(vt[i].din, vt[i].exp, $sformatf("vec%0d", i));

      // Backpressure with an ignored in_valid pulse while DONE
      send_s(8'd3);
      wait_valid_s(lat);
      chk("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_data", 64'(sb.out_data), 64'd189);
         chk("bp_in_ready", 64'(sb.in_ready), 64'd0);
         chk("bp_out_valid", 64'(sb.out_valid), 64'd1);
         sb.in_valid = (i == 4);
         sb.in_data  = 8'd1;
         sb.qH       = 4'd12;
         @(negedge clk);
      end
      sb.in_valid  = 1'b0;
      sb.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sb.out_ready = 1'b0;
      chk("bp_release", 64'({sb.out_valid, sb.in_ready}), 64'b01);
      repeat (5) @(negedge clk);
      chk("bp_no_ghost", 64'({sb.out_valid, sb.in_ready}), 64'b01);

      // Reset in the middle of RUN
      send_s(8'd2);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      chk("rrun_flags", 64'({sb.out_valid, sb.in_ready}), 64'b01);
      chk("rrun_out_data", 64'(sb.out_data), 64'd0);
      run_vec(8'd1, 8'd63, "rrun_after");

      // Reset while holding a result in DONE
      send_s(8'd192);
      wait_valid_s(lat);
      chk("rdone_pre", 64'(sb.out_data), 64'd130);
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      chk("rdone_flags", 64'({sb.out_valid, sb.in_ready}), 64'b01);
      chk("rdone_out_data", 64'(sb.out_data), 64'd0);

      // Default config: back-to-back traffic, qH/in_data scrambled while busy
      expq.delete();
      acc_n = 0; got_n = 0; last_acc = 0; done = 1'b0;
      db.out_ready = 1'b1;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         if (db.out_valid) begin
            if (expq.size() == 0) chk("dflt_spurious", 64'd1, 64'd0);
            else chk("dflt_result", 64'(db.out_data), 64'(expq.pop_front()));
            got_n++;
         end
         if (db.in_ready) begin
            if (acc_n < 6) begin
               qh   = 26'($urandom) | 26'h2000000;
               q128 = 128'({qh, 33'b0, 1'b1});
               r128 = {64'b0, $urandom, $urandom} % q128;
               xv   = r128[59:0];
               expq.push_back(gold(xv, qh));
               if (acc_n > 0) chk("dflt_interval", 64'(cyc - last_acc), 64'd19);
               last_acc = cyc;
               acc_n++;
               db.in_valid = 1'b1;
               db.in_data  = xv;
               db.qH       = qh;
            end else begin
               db.in_valid = 1'b0;
            end
         end else begin
            db.qH      = 26'($urandom);
            db.in_data = {28'($urandom), $urandom};
         end
         done = (got_n == 6);
      end
      if (!done) chk("dflt_timeout", 64'(got_n), 64'd6);
      db.in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
